// File: rtl/axi_defs.sv
// Shared AXI encodings and the read-chopper state type.
package axi_defs;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } chop_state_e;

endpackage

// File: rtl/axi_rd_chop.sv
// Splits one upstream AXI INCR read into CHOP_BEATS-sized downstream bursts
// and passes the returned data straight back, regenerating RLAST locally.
module axi_rd_chop
    import axi_defs::*;
#(
    parameter int ADDRS        = 32,
    parameter int WIDTH        = 32,
    parameter int MASKS        = WIDTH / 8,
    parameter int AXI_ID_WIDTH = 4,
    parameter int CHOP_BEATS   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    s_arvalid_i,
    output logic                    s_arready_o,
    input  logic [ADDRS-1:0]        s_araddr_i,
    input  logic [AXI_ID_WIDTH-1:0] s_arid_i,
    input  logic [7:0]              s_arlen_i,
    input  logic [1:0]              s_arburst_i,
    output logic                    s_rvalid_o,
    input  logic                    s_rready_i,
    output logic                    s_rlast_o,
    output logic [1:0]              s_rresp_o,
    output logic [AXI_ID_WIDTH-1:0] s_rid_o,
    output logic [WIDTH-1:0]        s_rdata_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    output logic [ADDRS-1:0]        m_araddr_o,
    output logic [AXI_ID_WIDTH-1:0] m_arid_o,
    output logic [7:0]              m_arlen_o,
    output logic [1:0]              m_arburst_o,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o,
    input  logic                    m_rlast_i,
    input  logic [1:0]              m_rresp_i,
    input  logic [AXI_ID_WIDTH-1:0] m_rid_i,
    input  logic [WIDTH-1:0]        m_rdata_i,
    output logic                    err_o
);

    localparam int                SUB_W    = $clog2(CHOP_BEATS);
    localparam logic [ADDRS-1:0]  STRIDE   = ADDRS'(CHOP_BEATS * MASKS);
    localparam logic [8:0]        CHOP9    = 9'(CHOP_BEATS);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CHOP_BEATS - 1);

    chop_state_e             state, state_nxt;
    logic [ADDRS-1:0]        addr_q;
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [8:0]              ar_left;
    logic [8:0]              beat_cnt;
    logic [SUB_W-1:0]        sub_cnt;
    logic                    arvalid_q;
    logic                    arready_q;
    logic                    err_q;

    logic busy;
    logic ar_hs;
    logic m_ar_hs;
    logic r_hs;
    logic last_chunk;
    logic sub_end;
    logic err_set;

    assign busy       = (state != IDLE);
    assign ar_hs      = s_arvalid_i & arready_q;
    assign m_ar_hs    = arvalid_q & m_arready_i;
    assign last_chunk = (ar_left <= CHOP9);

    assign s_arready_o = arready_q;
    assign m_arvalid_o = arvalid_q;
    assign m_araddr_o  = addr_q;
    assign m_arid_o    = id_q;
    assign m_arburst_o = BURST_INCR;
    assign m_arlen_o   = last_chunk ? (ar_left[7:0] - 8'd1) : 8'(CHOP_BEATS - 1);

    assign s_rvalid_o = busy & m_rvalid_i;
    assign m_rready_o = busy & s_rready_i;
    assign s_rdata_o  = m_rdata_i;
    assign s_rresp_o  = m_rresp_i;
    assign s_rid_o    = m_rid_i;
    assign r_hs       = s_rvalid_o & s_rready_i;
    assign s_rlast_o  = s_rvalid_o & (beat_cnt == 9'd1);

    // A sub-burst ends every CHOP_BEATS beats, or at the overall final beat.
    assign sub_end = (sub_cnt == SUB_LAST) | (beat_cnt == 9'd1);
    assign err_set = (ar_hs & (s_arburst_i != BURST_INCR))
                   | (~busy & m_rvalid_i)
                   | (r_hs & (m_rlast_i != sub_end));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = ISSUE;
            ISSUE:   if (m_ar_hs && last_chunk) state_nxt = DRAIN;
            DRAIN:   if (r_hs && (beat_cnt == 9'd1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AR handshakes (next sub-burst) and R handshakes (beat counting) can
    // land in the same cycle, so they update independent registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            id_q      <= '0;
            ar_left   <= '0;
            beat_cnt  <= '0;
            sub_cnt   <= '0;
            arvalid_q <= 1'b0;
            arready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            arready_q <= (state_nxt == IDLE);
            arvalid_q <= (state_nxt == ISSUE);
            err_q     <= err_q | err_set;
            if (ar_hs) begin
                addr_q   <= s_araddr_i;
                id_q     <= s_arid_i;
                ar_left  <= {1'b0, s_arlen_i} + 9'd1;
                beat_cnt <= {1'b0, s_arlen_i} + 9'd1;
                sub_cnt  <= '0;
            end else begin
                if (m_ar_hs) begin
                    if (last_chunk) begin
                        ar_left <= '0;
                    end else begin
                        ar_left <= ar_left - CHOP9;
                        addr_q  <= addr_q + STRIDE;
                    end
                end
                if (r_hs) begin
                    beat_cnt <= beat_cnt - 9'd1;
                    sub_cnt  <= sub_cnt + 1'b1;
                end
            end
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_axi_rd_chop.sv
// Scoreboard bench for axi_rd_chop: directed reads against a simple
// downstream memory model, expected AR/R traffic queued at issue time.
module tb_axi_rd_chop;
    import axi_defs::*;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
    } ar_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_arvalid_i = 1'b0;
    logic        s_arready_o;
    logic [31:0] s_araddr_i = '0;
    logic [3:0]  s_arid_i = '0;
    logic [7:0]  s_arlen_i = '0;
    logic [1:0]  s_arburst_i = BURST_INCR;
    logic        s_rvalid_o;
    logic        s_rready_i = 1'b0;
    logic        s_rlast_o;
    logic [1:0]  s_rresp_o;
    logic [3:0]  s_rid_o;
    logic [31:0] s_rdata_o;
    logic        m_arvalid_o;
    logic        m_arready_i = 1'b0;
    logic [31:0] m_araddr_o;
    logic [3:0]  m_arid_o;
    logic [7:0]  m_arlen_o;
    logic [1:0]  m_arburst_o;
    logic        m_rvalid_i = 1'b0;
    logic        m_rready_o;
    logic        m_rlast_i = 1'b0;
    logic [1:0]  m_rresp_i = AXI_RESP_OKAY;
    logic [3:0]  m_rid_i = '0;
    logic [31:0] m_rdata_i = '0;
    logic        err_o;

    ar_t   exp_ar[$];
    beat_t exp_r[$];
    beat_t pend[$];

    int n_compared = 0;
    int n_mismatched = 0;
    bit back_pressure = 1'b0;
    bit hold_r = 1'b0;
    bit inject_last = 1'b0;
    bit r_taken = 1'b0;

    always #5 clock = ~clock;

    axi_rd_chop #(
        .ADDRS(32), .WIDTH(32), .MASKS(4), .AXI_ID_WIDTH(4), .CHOP_BEATS(4)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_araddr_i(s_araddr_i), .s_arid_i(s_arid_i),
        .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
        .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .s_rlast_o(s_rlast_o), .s_rresp_o(s_rresp_o),
        .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o),
        .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_araddr_o(m_araddr_o), .m_arid_o(m_arid_o),
        .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .m_rlast_i(m_rlast_i), .m_rresp_i(m_rresp_i),
        .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i),
        .err_o(err_o)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ {16'h0, a[31:16]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Downstream slave: accepts sub-bursts, checks them, then returns
    // beats read from a fixed address-derived memory pattern.
    initial begin
        beat_t b;
        ar_t   e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                pend.delete();
                m_rvalid_i = 1'b0;
                m_rlast_i  = 1'b0;
                r_taken    = 1'b0;
            end else begin
                m_arready_i = back_pressure ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!m_rvalid_i || r_taken) begin
                    if (pend.size() > 0 && (!back_pressure || $urandom_range(0, 3) != 0)) begin
                        b = pend.pop_front();
                        m_rvalid_i = 1'b1;
                        m_rdata_i  = b.data;
                        m_rlast_i  = b.last;
                        m_rid_i    = b.id;
                    end else begin
                        m_rvalid_i = 1'b0;
                        m_rlast_i  = 1'b0;
                    end
                end
            end
            #1;
            r_taken = m_rvalid_i & m_rready_o;
            if (reset_n && m_arvalid_o && m_arready_i) begin
                if (exp_ar.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_ar: got addr %0h, expected none", m_araddr_o);
                end else begin
                    e = exp_ar.pop_front();
                    checkOutput("ar_addr", m_araddr_o, e.addr);
                    checkOutput("ar_len", m_arlen_o, e.len);
                    checkOutput("ar_id", m_arid_o, e.id);
                    checkOutput("ar_burst", m_arburst_o, BURST_INCR);
                end
                for (int j = 0; j <= int'(m_arlen_o); j++) begin
                    b.data = mem_data(m_araddr_o + 32'(j * 4));
                    b.last = (j == int'(m_arlen_o)) || (inject_last && j == 1);
                    b.id   = m_arid_o;
                    pend.push_back(b);
                end
                inject_last = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            s_rready_i = hold_r ? 1'b0 : (back_pressure ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Upstream monitor: every accepted beat must match the scoreboard.
    initial begin
        beat_t e;
        forever begin
            @(negedge clock);
            #1;
            if (s_rvalid_o && s_rready_i) begin
                if (exp_r.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_r: got data %0h, expected none", s_rdata_o);
                end else begin
                    e = exp_r.pop_front();
                    checkOutput("r_data", s_rdata_o, e.data);
                    checkOutput("r_last", s_rlast_o, e.last);
                    checkOutput("r_id", s_rid_o, e.id);
                    checkOutput("r_resp", s_rresp_o, AXI_RESP_OKAY);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] arlen,
                                 input logic [3:0] id, input logic [1:0] burst,
                                 input int n_sub, input logic [7:0] last_len);
        ar_t   a;
        beat_t b;
        bit    got = 1'b0;
        for (int k = 0; k < n_sub; k++) begin
            a.addr = addr + 32'(k * 16);
            a.len  = (k == n_sub - 1) ? last_len : 8'd3;
            a.id   = id;
            exp_ar.push_back(a);
        end
        for (int i = 0; i <= int'(arlen); i++) begin
            b.data = mem_data(addr + 32'(i * 4));
            b.last = (i == int'(arlen));
            b.id   = id;
            exp_r.push_back(b);
        end
        @(negedge clock);
        s_arvalid_i = 1'b1;
        s_araddr_i  = addr;
        s_arlen_i   = arlen;
        s_arid_i    = id;
        s_arburst_i = burst;
        for (int t = 0; t < 50 && !got; t++) begin
            #1;
            if (s_arready_o) got = 1'b1;
            @(negedge clock);
        end
        s_arvalid_i = 1'b0;
        s_arburst_i = BURST_INCR;
        if (!got) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL ar_accept: got no s_arready_o, expected one within 50 cycles");
        end
    endtask

    task automatic waitDone(input string name);
        for (int t = 0; t < 6000 && (exp_r.size() != 0 || exp_ar.size() != 0); t++)
            @(negedge clock);
        checkOutput(name, 64'(exp_r.size() + exp_ar.size()), 64'd0);
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_arready", s_arready_o, 1'b0);
        checkOutput("rst_arvalid", m_arvalid_o, 1'b0);
        checkOutput("rst_err", err_o, 1'b0);
        #2 reset_n = 1'b1;
        #1 checkOutput("rst_arready_pre_edge", s_arready_o, 1'b0);
        @(posedge clock);
        #1 checkOutput("rst_arready_post_edge", s_arready_o, 1'b1);

        applyStimulus(32'h0000_0100, 8'd0, 4'h1, BURST_INCR, 1, 8'd0);
        waitDone("single_beat_done");
        applyStimulus(32'h0000_1000, 8'd15, 4'h2, BURST_INCR, 4, 8'd3);
        waitDone("len16_done");
        applyStimulus(32'h0000_2000, 8'd5, 4'h3, BURST_INCR, 2, 8'd1);
        waitDone("len6_done");
        applyStimulus(32'hFFFF_FFF0, 8'd7, 4'h4, BURST_INCR, 2, 8'd3);
        waitDone("addr_wrap_done");

        back_pressure = 1'b1;
        applyStimulus(32'h0000_4000, 8'd255, 4'h5, BURST_INCR, 64, 8'd3);
        waitDone("len256_done");
        back_pressure = 1'b0;
        checkOutput("err_clean", err_o, 1'b0);

        inject_last = 1'b1;
        applyStimulus(32'h0000_5000, 8'd7, 4'h6, BURST_INCR, 2, 8'd3);
        waitDone("early_last_done");
        checkOutput("err_early_last", err_o, 1'b1);
        applyStimulus(32'h0000_5800, 8'd1, 4'h7, BURST_INCR, 1, 8'd1);
        waitDone("sticky_done");
        checkOutput("err_sticky", err_o, 1'b1);

        hold_r = 1'b1;
        applyStimulus(32'h0000_6000, 8'd3, 4'h9, BURST_INCR, 1, 8'd3);
        repeat (4) @(negedge clock);
        #1 checkOutput("drain_rvalid", s_rvalid_o, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_arready", s_arready_o, 1'b0);
        checkOutput("mid_rst_arvalid", m_arvalid_o, 1'b0);
        checkOutput("mid_rst_rvalid", s_rvalid_o, 1'b0);
        checkOutput("mid_rst_rready", m_rready_o, 1'b0);
        checkOutput("mid_rst_err", err_o, 1'b0);
        exp_r.delete();
        exp_ar.delete();
        @(negedge clock);
        #3 reset_n = 1'b1;
        hold_r = 1'b0;
        #1 checkOutput("rerst_arready_pre_edge", s_arready_o, 1'b0);
        @(posedge clock);
        #1 checkOutput("rerst_arready_post_edge", s_arready_o, 1'b1);
        applyStimulus(32'h0000_6000, 8'd3, 4'hA, BURST_INCR, 1, 8'd3);
        waitDone("post_reset_done");
        checkOutput("post_reset_err", err_o, 1'b0);

        applyStimulus(32'h0000_7000, 8'd3, 4'hB, 2'b10, 1, 8'd3);
        waitDone("wrap_as_incr_done");
        checkOutput("err_bad_burst", err_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
